// File: rtl/lvds_rx_pkg.sv
// Shared types and parameter helpers for the LVDS frame receiver.
package lvds_rx_pkg;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RECV     = 2'd2
  } state_e;

  // Beats needed per assembled word
  function automatic int unsigned calc_bpl(input int unsigned lanes,
                                           input int unsigned word_w);
    return word_w / lanes;
  endfunction

  // Beat counter width, never narrower than one bit
  function automatic int unsigned calc_beat_w(input int unsigned bpl);
    return (bpl > 1) ? $clog2(bpl) : 1;
  endfunction

endpackage

// File: rtl/lvds_rx_deser_lane_shift.sv
// Per-lane BPL-bit LSB-first shift register; next_c_o is the value after the
// current beat is shifted in, so a word can be taken on its last beat.
module lvds_lane_shift
  import lvds_rx_pkg::*;
#(
  parameter int unsigned BPL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_i,
  input  logic           bit_i,
  output logic [BPL-1:0] next_c_o
);

  logic [BPL-1:0] sreg_q;
  logic [BPL-1:0] sreg_d;

  // New beat enters at the MSB so the first beat ends up at bit 0
  if (BPL == 1) begin : g_one
    assign sreg_d = bit_i;
  end else begin : g_multi
    assign sreg_d = {bit_i, sreg_q[BPL-1:1]};
  end

  // Shift register state
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (shift_i) begin
      sreg_q <= sreg_d;
    end
  end

  assign next_c_o = sreg_d;

endmodule

// File: rtl/lvds_rx_deser.sv
// LVDS source-synchronous frame receiver: deserialises LANES lanes framed by
// lvds_flag into WORD_W-bit words with SOF/EOF, frame length and error status.
// Optional build macro LVDS_RX_LEN_CHECK_EN enables the expected-length check.
module lvds_rx_deser
  import lvds_rx_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lvds_flag,
  input  logic [LANES-1:0]  lvds_data,
  input  logic [CNT_W-1:0]  exp_len,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eof,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_len,
  output logic              align_err,
  output logic              len_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned      BPL       = calc_bpl(LANES, WORD_W);
  localparam int unsigned      BW        = calc_beat_w(BPL);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BPL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q,      state_d;
  logic [BW-1:0]     beat_q,       beat_d;
  logic [CNT_W-1:0]  word_cnt_q,   word_cnt_d;
  logic              first_q,      first_d;
  logic [WORD_W-1:0] hold_q,       hold_d;
  logic              hold_vld_q,   hold_vld_d;
  logic [WORD_W-1:0] m_data_q,     m_data_d;
  logic              m_valid_q,    m_valid_d;
  logic              m_sof_q,      m_sof_d;
  logic              m_eof_q,      m_eof_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_len_q,  frame_len_d;
  logic              align_err_q,  align_err_d;
  logic              len_err_q,    len_err_d;
  logic [CNT_W-1:0]  frame_cnt_q,  frame_cnt_d;

  logic              shift_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;

`ifdef LVDS_RX_LEN_CHECK_EN
  logic [CNT_W-1:0]  exp_q, exp_d;
`else
  logic              unused_exp_len;
  assign unused_exp_len = ^exp_len;
`endif

  // One shift register per lane; lane k owns word bits [k*BPL +: BPL]
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    lvds_lane_shift #(
      .BPL(BPL)
    ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .shift_i (shift_c),
      .bit_i   (lvds_data[k]),
      .next_c_o(word_c[k*BPL +: BPL])
    );
  end

  // Next-state, word release, counters and end-of-frame status
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    word_cnt_d   = word_cnt_q;
    first_d      = first_q;
    hold_d       = hold_q;
    hold_vld_d   = 1'b0;
    m_data_d     = m_data_q;
    m_valid_d    = 1'b0;
    m_sof_d      = 1'b0;
    m_eof_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    align_err_d  = align_err_q;
    len_err_d    = len_err_q;
    frame_cnt_d  = frame_cnt_q;
    shift_c      = 1'b0;
    word_done_c  = 1'b0;
`ifdef LVDS_RX_LEN_CHECK_EN
    exp_d        = exp_q;
`endif

    // A held word goes out one sample later; that sample decides EOF
    if (hold_vld_q) begin
      m_valid_d = 1'b1;
      m_data_d  = hold_q;
      m_sof_d   = first_q;
      m_eof_d   = !lvds_flag;
      first_d   = 1'b0;
    end

    case (state_q)
      ST_WAIT_LOW: begin
        if (!lvds_flag) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (lvds_flag) begin
          shift_c    = 1'b1;
          word_cnt_d = '0;
          first_d    = 1'b1;
          state_d    = ST_RECV;
`ifdef LVDS_RX_LEN_CHECK_EN
          exp_d      = exp_len;
`endif
          if (BPL == 1) begin
            word_done_c = 1'b1;
          end else begin
            beat_d = BW'(1);
          end
        end
      end
      ST_RECV: begin
        if (lvds_flag) begin
          shift_c = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            word_done_c = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d      = ST_IDLE;
          beat_d       = '0;
          frame_done_d = 1'b1;
          frame_len_d  = word_cnt_q;
          align_err_d  = (beat_q != '0);
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
`ifdef LVDS_RX_LEN_CHECK_EN
          len_err_d    = ((exp_q != '0) && (word_cnt_q != exp_q)) ||
                         (word_cnt_q == CNT_MAX);
`else
          len_err_d    = 1'b0;
`endif
        end
      end
      default: state_d = ST_WAIT_LOW;
    endcase

    // Completed word moves to the hold register; word count saturates
    if (word_done_c) begin
      hold_d     = word_c;
      hold_vld_d = 1'b1;
      if (word_cnt_d != CNT_MAX) word_cnt_d = word_cnt_d + CNT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAIT_LOW;
      beat_q       <= '0;
      word_cnt_q   <= '0;
      first_q      <= 1'b0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      align_err_q  <= 1'b0;
      len_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef LVDS_RX_LEN_CHECK_EN
      exp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      word_cnt_q   <= word_cnt_d;
      first_q      <= first_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      align_err_q  <= align_err_d;
      len_err_q    <= len_err_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef LVDS_RX_LEN_CHECK_EN
      exp_q        <= exp_d;
`endif
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign align_err  = align_err_q;
  assign len_err    = len_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Bench for lvds_rx_deser: frame-level reference model checked every cycle,
// directed frames from the test plan, random frames, and a 4-lane instance.
`timescale 1ns/1ps
module tb_lvds_rx_deser;

  localparam int LANES  = 2;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 16;
  localparam int BPL    = WORD_W / LANES;

  logic              clk = 1'b0;
  logic              rst;
  logic              lvds_flag;
  logic [LANES-1:0]  lvds_data;
  logic [CNT_W-1:0]  exp_len;
  logic [WORD_W-1:0] m_data;
  logic              m_valid, m_sof, m_eof, frame_done, align_err, len_err;
  logic [CNT_W-1:0]  frame_len, frame_cnt;

  // 4-lane / 16-bit instance
  logic              rst4, flag4;
  logic [3:0]        data4;
  logic [15:0]       exp4;
  logic [15:0]       m_data4;
  logic              m_valid4, m_sof4, m_eof4, frame_done4, align_err4, len_err4;
  logic [15:0]       frame_len4, frame_cnt4;

  always #5 clk = ~clk;

  lvds_rx_deser #(.LANES(LANES), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .lvds_flag(lvds_flag), .lvds_data(lvds_data),
    .exp_len(exp_len), .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof),
    .m_eof(m_eof), .frame_done(frame_done), .frame_len(frame_len),
    .align_err(align_err), .len_err(len_err), .frame_cnt(frame_cnt)
  );

  lvds_rx_deser #(.LANES(4), .WORD_W(16), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst4), .lvds_flag(flag4), .lvds_data(data4),
    .exp_len(exp4), .m_data(m_data4), .m_valid(m_valid4), .m_sof(m_sof4),
    .m_eof(m_eof4), .frame_done(frame_done4), .frame_len(frame_len4),
    .align_err(align_err4), .len_err(len_err4), .frame_cnt(frame_cnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level, from the spec's rules) ----
  bit                armed, in_frame, pend, pend_sof;
  logic [WORD_W-1:0] pend_word;
  logic [LANES-1:0]  beats [BPL];
  int                nbeat;
  logic [CNT_W-1:0]  nwords, exp_cap;
  bit                e_valid, e_sof, e_eof, e_done, e_align, e_lerr;
  logic [WORD_W-1:0] e_data;
  logic [CNT_W-1:0]  e_len, e_fcnt;
  int                nv;

  // Word bit k*BPL+j comes from lane k on beat j
  function automatic logic [WORD_W-1:0] assemble();
    logic [WORD_W-1:0] w = '0;
    for (int j = 0; j < BPL; j++)
      for (int k = 0; k < LANES; k++)
        w[k*BPL+j] = beats[j][k];
    return w;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_done = 1'b0;
      if (rst) begin
        armed = 1'b0; in_frame = 1'b0; pend = 1'b0; nbeat = 0; nv = 0;
        e_data = '0; e_len = '0; e_align = 1'b0; e_lerr = 1'b0; e_fcnt = '0;
      end else begin
        if (pend) begin
          e_valid = 1'b1; e_data = pend_word; e_sof = pend_sof;
          e_eof = !lvds_flag; pend = 1'b0;
        end
        if (in_frame && !lvds_flag) begin
          e_done  = 1'b1;
          e_len   = nwords;
          e_align = (nbeat != 0);
`ifdef LVDS_RX_LEN_CHECK_EN
          e_lerr  = ((exp_cap != '0) && (nwords != exp_cap)) || (nwords == '1);
`else
          e_lerr  = 1'b0;
`endif
          e_fcnt  = e_fcnt + 1'b1;
          in_frame = 1'b0; nbeat = 0;
        end else if (!in_frame && armed && lvds_flag) begin
          in_frame = 1'b1; nwords = '0; nbeat = 0; exp_cap = exp_len;
        end
        if (in_frame && lvds_flag) begin
          beats[nbeat] = lvds_data;
          nbeat++;
          if (nbeat == BPL) begin
            pend_word = assemble();
            pend_sof  = (nwords == '0);
            pend      = 1'b1;
            nbeat     = 0;
            if (nwords != '1) nwords = nwords + 1'b1;
          end
        end
        if (!lvds_flag) armed = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and per-frame log ----------------------
  int log_len[$], log_cnt[$], log_align[$], log_lerr[$], log_nv[$], log_sof[$], log_eof[$];
  int sof_d = -1;
  int eof_d = -1;

  initial begin
    forever begin
      @(negedge clk);
      check("m_valid", 32'(m_valid), 32'(e_valid));
      if (e_valid) begin
        check("m_data", 32'(m_data), 32'(e_data));
        check("m_sof",  32'(m_sof),  32'(e_sof));
        check("m_eof",  32'(m_eof),  32'(e_eof));
      end
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("frame_len",  32'(frame_len),  32'(e_len));
      check("align_err",  32'(align_err),  32'(e_align));
      check("len_err",    32'(len_err),    32'(e_lerr));
      check("frame_cnt",  32'(frame_cnt),  32'(e_fcnt));
      if (m_valid === 1'b1) begin
        nv++;
        if (m_sof === 1'b1) sof_d = int'(m_data);
        if (m_eof === 1'b1) eof_d = int'(m_data);
      end
      if (frame_done === 1'b1) begin
        log_len.push_back(int'(frame_len));   log_cnt.push_back(int'(frame_cnt));
        log_align.push_back(int'(align_err)); log_lerr.push_back(int'(len_err));
        log_nv.push_back(nv); log_sof.push_back(sof_d); log_eof.push_back(eof_d);
        nv = 0; sof_d = -1; eof_d = -1;
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------------
  task automatic drive_frame(input int nbeats, input int start, input bit rnd,
                             input int exp0, input int gap, input int rst_at);
    logic [WORD_W-1:0] w = '0;
    int j;
    for (int b = 0; b < nbeats; b++) begin
      j = b % BPL;
      if (j == 0) w = rnd ? WORD_W'($urandom) : WORD_W'(start + b / BPL);
      @(negedge clk);
      lvds_flag = 1'b1;
      for (int k = 0; k < LANES; k++) lvds_data[k] = w[k*BPL+j];
      rst = (b == rst_at);
      if (b == 0) exp_len = CNT_W'(exp0);
      if (rnd && b == 1) exp_len = CNT_W'($urandom_range(0, 20));
    end
    @(negedge clk);
    lvds_flag = 1'b0; lvds_data = '0; rst = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_log(input int idx, input string tag, input int len, input int cnt,
                           input int align, input int lerr, input int nwords, input int sof);
    check({tag, " logged"}, 32'(log_len.size() > idx), 32'd1);
    if (log_len.size() > idx) begin
      check({tag, " frame_len"}, 32'(log_len[idx]),   32'(len));
      check({tag, " frame_cnt"}, 32'(log_cnt[idx]),   32'(cnt));
      check({tag, " align_err"}, 32'(log_align[idx]), 32'(align));
      check({tag, " len_err"},   32'(log_lerr[idx]),  32'(lerr));
      check({tag, " words"},     32'(log_nv[idx]),    32'(nwords));
      check({tag, " sof word"},  32'(log_sof[idx]),   32'(sof));
    end
  endtask

  logic [3:0] tab4 [4];

  initial begin
    int nb, ch, e0, rat, got;
    rst = 1'b1; lvds_flag = 1'b0; lvds_data = '0; exp_len = '0;
    rst4 = 1'b1; flag4 = 1'b0; data4 = '0; exp4 = '0;
    tab4 = '{4'b0101, 4'b1001, 4'b0110, 4'b1010};
    repeat (3) @(negedge clk);
    check("reset m_valid",   32'(m_valid),   32'd0);
    check("reset m_data",    32'(m_data),    32'd0);
    check("reset frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset frame_len", 32'(frame_len), 32'd0);
    check("reset align_err", 32'(align_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    drive_frame(3584, 8'h01, 1'b0, 896, 1, -1);  // A
    drive_frame(3584, 8'h81, 1'b0, 896, 4, -1);  // B, one-cycle gap before it
    drive_frame(3585, 8'h01, 1'b0, 896, 4, -1);  // C, one extra beat
    drive_frame(3584, 8'h01, 1'b0, 895, 4, -1);  // L1
    drive_frame(3584, 8'h01, 1'b0, 0,   4, -1);  // L2
    drive_frame(600,  8'h01, 1'b0, 0,   3, 400); // reset at word 100
    drive_frame(40,   8'h11, 1'b0, 10,  4, -1);  // clean frame after reset

    check_log(0, "A", 896, 1, 0, 0, 896, 8'h01);
    if (log_eof.size() > 0) check("A eof word", 32'(log_eof[0]), 32'h80);
    check_log(1, "B", 896, 2, 0, 0, 896, 8'h81);
    if (log_eof.size() > 1) check("B eof word", 32'(log_eof[1]), 32'h00);
    check_log(2, "C", 896, 3, 1, 0, 896, 8'h01);
`ifdef LVDS_RX_LEN_CHECK_EN
    check_log(3, "L1", 896, 4, 0, 1, 896, 8'h01);
`else
    check_log(3, "L1", 896, 4, 0, 0, 896, 8'h01);
`endif
    check_log(4, "L2", 896, 5, 0, 0, 896, 8'h01);
    check_log(5, "after reset", 10, 1, 0, 0, 10, 8'h11);
    check("frames logged", 32'(log_len.size()), 32'd6);

    for (int f = 0; f < 60; f++) begin
      nb  = $urandom_range(1, 70);
      ch  = $urandom_range(0, 2);
      e0  = (ch == 0) ? 0 : (ch == 1) ? nb / BPL : $urandom_range(0, 20);
      rat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
      drive_frame(nb, 0, 1'b1, e0, $urandom_range(1, 3), rat);
    end

    // 4-lane word 0xA5C3: lane k carries nibble k, LSB first
    @(negedge clk); rst4 = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); flag4 = 1'b1; data4 = tab4[b];
    end
    @(negedge clk); flag4 = 1'b0; data4 = '0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (m_valid4 === 1'b1) begin
        got = 1;
        check("lane4 m_data",     32'(m_data4),     32'hA5C3);
        check("lane4 m_sof",      32'(m_sof4),      32'd1);
        check("lane4 m_eof",      32'(m_eof4),      32'd1);
        check("lane4 frame_done", 32'(frame_done4), 32'd1);
        check("lane4 latency",    32'(i),           32'd0);
      end
    end
    check("lane4 m_valid seen", 32'(got), 32'd1);
    @(negedge clk);
    check("lane4 frame_len", 32'(frame_len4), 32'd1);
    check("lane4 align_err", 32'(align_err4), 32'd0);
    check("lane4 frame_cnt", 32'(frame_cnt4), 32'd1);
    check("lane4 len_err",   32'(len_err4),   32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
